// File: rtl/fft_ctrl_regs.sv
// Control-register responder for the FFT core: point-size config, start/busy/done
// sequencing and a stretched soft reset, behind the scan register mux handshake.
module fft_ctrl_regs #(
  parameter logic [2:0]  PNT_CFG_RST = 3'd7,
  parameter int unsigned RST_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pnt_cfg_ren,
  input  logic        pnt_cfg_wen,
  input  logic [2:0]  pnt_cfg_wdata,
  output logic [10:0] pnt_cfg_rdata,
  output logic        pnt_cfg_ready,
  input  logic        start_fft_ren,
  input  logic        start_fft_wen,
  input  logic        start_fft_wdata,
  output logic        start_fft_rdata,
  output logic        start_fft_ready,
  input  logic        reset_fft_ren,
  input  logic        reset_fft_wen,
  input  logic        reset_fft_wdata,
  output logic        reset_fft_rdata,
  output logic        reset_fft_ready,
  input  logic        fft_done,
  output logic [10:0] fft_npoint,
  output logic        fft_start,
  output logic        fft_soft_rst
);

  typedef enum logic [1:0] {IDLE, START, RUN, SRST} state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  state_t     state;
  logic [2:0] cfg;
  logic [7:0] rst_cnt;
  logic       start_req;
  logic       srst_req;

  assign start_req = start_fft_wen & start_fft_wdata;
  assign srst_req  = reset_fft_wen & reset_fft_wdata;

  // Code c selects 2^(c+3) points, so the count is simply 8 shifted by the code.
  assign fft_npoint      = 11'd8 << cfg;
  assign pnt_cfg_rdata   = fft_npoint;
  assign start_fft_rdata = (state != IDLE);
  assign reset_fft_rdata = (state == SRST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cfg             <= PNT_CFG_RST;
      rst_cnt         <= 8'd0;
      pnt_cfg_ready   <= 1'b0;
      start_fft_ready <= 1'b0;
      reset_fft_ready <= 1'b0;
      fft_start       <= 1'b0;
      fft_soft_rst    <= 1'b0;
    end else begin
      pnt_cfg_ready   <= pnt_cfg_ren | pnt_cfg_wen;
      start_fft_ready <= start_fft_ren | start_fft_wen;
      reset_fft_ready <= reset_fft_ren | reset_fft_wen;
      fft_start       <= 1'b0;

      if (pnt_cfg_wen && state == IDLE)
        cfg <= pnt_cfg_wdata;

      // A soft-reset write wins over start requests and fft_done in every state.
      if (srst_req) begin
        state        <= SRST;
        rst_cnt      <= RST_LOAD;
        fft_soft_rst <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_req) begin
              state     <= START;
              fft_start <= 1'b1;
            end
          end
          START: state <= RUN;
          RUN: begin
            if (fft_done)
              state <= IDLE;
          end
          SRST: begin
            if (rst_cnt <= 8'd1) begin
              rst_cnt      <= 8'd0;
              fft_soft_rst <= 1'b0;
              state        <= IDLE;
            end else begin
              rst_cnt <= rst_cnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
